// File: rtl/video_line_doubler_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the video line doubler.
package video_line_doubler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COPY0 = 2'd1,
      COPY1 = 2'd2
   } rd_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/video_line_ram.sv
`timescale 1ns/1ps
// Simple dual-port line RAM: one write port, one registered read port.
module video_line_ram #(
   parameter int DW = 4,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   // No reset on purpose, so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/video_line_doubler.sv
`timescale 1ns/1ps
// Line doubler: ping-pong line buffer, previous line replayed twice
// at out_ce rate with its own hsync and optional scanline dimming.
module video_line_doubler
   import video_line_doubler_pkg::*;
#(
   parameter int PIXEL_W = 4,
   parameter int LINE_MAX = 1024,
   parameter int HS_WIDTH = 80,
   parameter logic [PIXEL_W-1:0] DIM_MASK = 4'b1000
) (
   input  logic               clk,
   input  logic               reset_l,
   input  logic               in_ce,
   input  logic               line_reset,
   input  logic [PIXEL_W-1:0] video,
   input  logic               out_ce,
   input  logic               scanline_en,
   output logic [PIXEL_W-1:0] dbl_video,
   output logic               dbl_hsync,
   output logic               overflow
);

   localparam int ADDR_W = clog2(LINE_MAX + 1);
   localparam int IDX_W = (LINE_MAX > 1) ? clog2(LINE_MAX) : 1;
   localparam logic [ADDR_W-1:0] LMAX = ADDR_W'(LINE_MAX);

   logic              wbank_q, wbank_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] rlen_q, rlen_d;
   logic              ovf_seen_q, ovf_seen_d;
   logic              overflow_q, overflow_d;
   logic              we, wsel;
   logic [IDX_W-1:0]  widx;

   always_comb begin
      wbank_d    = wbank_q;
      wcnt_d     = wcnt_q;
      rlen_d     = rlen_q;
      ovf_seen_d = ovf_seen_q;
      overflow_d = 1'b0;
      we         = 1'b0;
      wsel       = wbank_q;
      widx       = wcnt_q[IDX_W-1:0];
      if (line_reset) begin
         // wcnt never passes LINE_MAX, so it is already saturated
         rlen_d     = wcnt_q;
         wbank_d    = ~wbank_q;
         ovf_seen_d = 1'b0;
         wcnt_d     = in_ce ? ADDR_W'(1) : '0;
         we         = in_ce;
         wsel       = ~wbank_q;
         widx       = '0;
      end else if (in_ce) begin
         if (wcnt_q != LMAX) begin
            we     = 1'b1;
            wcnt_d = wcnt_q + ADDR_W'(1);
         end else if (!ovf_seen_q) begin
            overflow_d = 1'b1;
            ovf_seen_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wbank_q    <= 1'b0;
         wcnt_q     <= '0;
         rlen_q     <= '0;
         ovf_seen_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wbank_q    <= wbank_d;
         wcnt_q     <= wcnt_d;
         rlen_q     <= rlen_d;
         ovf_seen_q <= ovf_seen_d;
         overflow_q <= overflow_d;
      end
   end

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] rcnt_q, rcnt_d;
   logic              last;

   assign last = (rcnt_q == rlen_q - ADDR_W'(1));

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      if (line_reset) begin
         rcnt_d  = '0;
         state_d = (wcnt_q == '0) ? IDLE : COPY0;
      end else if (out_ce) begin
         unique case (state_q)
            COPY0: begin
               rcnt_d  = last ? '0 : rcnt_q + ADDR_W'(1);
               state_d = last ? COPY1 : COPY0;
            end
            COPY1: begin
               rcnt_d  = last ? '0 : rcnt_q + ADDR_W'(1);
               state_d = last ? IDLE : COPY1;
            end
            default: ;
         endcase
      end
   end

   logic tick, blank, dim, hs;

   always_comb begin
      tick  = out_ce && !line_reset;
      blank = (state_q == IDLE);
      dim   = (state_q == COPY1) && scanline_en;
      hs    = !blank && (int'(rcnt_q) < HS_WIDTH);
   end

   logic [PIXEL_W-1:0] rdata;

   video_line_ram #(
      .DW(PIXEL_W),
      .AW(IDX_W + 1)
   ) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i ({wsel, widx}),
      .wdata_i (video),
      .re_i    (tick),
      .raddr_i ({~wbank_q, rcnt_q[IDX_W-1:0]}),
      .rdata_o (rdata)
   );

   logic               vld_q, blank_q, dim_q, hs_q;
   logic [PIXEL_W-1:0] dbl_video_q;
   logic               dbl_hsync_q;

   // Stage 1 tracks the RAM read; stage 2 is the output register.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         vld_q       <= 1'b0;
         blank_q     <= 1'b1;
         dim_q       <= 1'b0;
         hs_q        <= 1'b0;
         dbl_video_q <= '0;
         dbl_hsync_q <= 1'b0;
      end else begin
         vld_q   <= tick;
         blank_q <= blank;
         dim_q   <= dim;
         hs_q    <= hs;
         if (vld_q) begin
            dbl_hsync_q <= hs_q;
            if (blank_q) dbl_video_q <= '0;
            else if (dim_q) dbl_video_q <= rdata & ~DIM_MASK;
            else dbl_video_q <= rdata;
         end
      end
   end

   assign dbl_video = dbl_video_q;
   assign dbl_hsync = dbl_hsync_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_video_line_doubler.sv
`timescale 1ns/1ps
// Directed bench for video_line_doubler (LINE_MAX=16, HS_WIDTH=4).
module tb_video_line_doubler;

   localparam int HSW = 4;

   logic       clk = 1'b0;
   logic       reset_l = 1'b0;
   logic       in_ce = 1'b0;
   logic       line_reset = 1'b0;
   logic [3:0] video = 4'h0;
   logic       out_ce = 1'b0;
   logic       scanline_en = 1'b0;
   logic [3:0] dbl_video;
   logic       dbl_hsync;
   logic       overflow;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   video_line_doubler #(
      .PIXEL_W(4),
      .LINE_MAX(16),
      .HS_WIDTH(HSW),
      .DIM_MASK(4'b1000)
   ) dut (
      .clk         (clk),
      .reset_l     (reset_l),
      .in_ce       (in_ce),
      .line_reset  (line_reset),
      .video       (video),
      .out_ce      (out_ce),
      .scanline_en (scanline_en),
      .dbl_video   (dbl_video),
      .dbl_hsync   (dbl_hsync),
      .overflow    (overflow)
   );

   typedef struct {
      int         npix;
      logic [3:0] base;
      logic       inc;
      logic       scan;
      int         len;
      int         ovf_at;
   } vec_t;

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, got, exp);
      end
   endtask

   function automatic logic [3:0] pix(input logic [3:0] b,
                                      input logic inc, input int i);
      logic [3:0] o;
      o = inc ? b + 4'(i) : b;
      return o;
   endfunction

   task automatic step(input logic ic, input logic [3:0] px,
                       input logic oc, input logic lr);
      in_ce = ic;
      video = px;
      out_ce = oc;
      line_reset = lr;
      @(posedge clk);
      #1;
      in_ce = 1'b0;
      out_ce = 1'b0;
      line_reset = 1'b0;
   endtask

   // One out_ce tick, then check the pixel it addressed 2 clk later.
   task automatic tick(input logic ic, input logic [3:0] px,
                       input logic [3:0] ev, input logic eh,
                       input string nm, input int idx);
      step(ic, px, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0);
      chk({nm, " video"}, idx, dbl_video, ev);
      chk({nm, " hsync"}, idx, dbl_hsync, eh);
   endtask

   task automatic write_line(input int n, input logic [3:0] b,
                             input logic inc, input int ovf_at,
                             input string nm);
      int pulses;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b1, pix(b, inc, i), 1'b0, 1'b0);
         chk({nm, " ovf"}, i, overflow, i == ovf_at);
         if (overflow) pulses++;
         step(1'b0, 4'h0, 1'b0, 1'b0);
         if (overflow) pulses++;
      end
      chk({nm, " ovf_pulses"}, 0, pulses, (ovf_at >= 0) ? 1 : 0);
   endtask

   task automatic replay(input int len, input logic [3:0] b,
                         input logic inc, input logic scan,
                         input string nm);
      logic [3:0] ev;
      scanline_en = scan;
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < len; i++) begin
            ev = pix(b, inc, i);
            if (c == 1 && scan) ev = ev & 4'h7;
            tick(1'b0, 4'h0, ev, i < HSW, nm, c * len + i);
         end
      end
      tick(1'b0, 4'h0, 4'h0, 1'b0, {nm, " idle"}, 0);
      scanline_en = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: summary not reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vt[7];
      logic [3:0] ev;
      int i;
      vt[0] = '{12, 4'h3, 1'b1, 1'b0, 12, -1};
      vt[1] = '{12, 4'hA, 1'b1, 1'b1, 12, -1};
      vt[2] = '{10, 4'hF, 1'b0, 1'b1, 10, -1};
      vt[3] = '{20, 4'h0, 1'b1, 1'b0, 16, 16};
      vt[4] = '{16, 4'h5, 1'b1, 1'b1, 16, -1};
      vt[5] = '{2, 4'h9, 1'b1, 1'b0, 2, -1};
      vt[6] = '{1, 4'hC, 1'b0, 1'b1, 1, -1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst video", 0, dbl_video, 4'h0);
      chk("rst hsync", 0, dbl_hsync, 1'b0);
      chk("rst ovf", 0, overflow, 1'b0);
      #2 reset_l = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 7; v++) begin
         step(1'b0, 4'h0, 1'b0, 1'b1);
         write_line(vt[v].npix, vt[v].base, vt[v].inc,
                    vt[v].ovf_at, $sformatf("vec%0d", v));
         step(1'b0, 4'h0, 1'b0, 1'b1);
         replay(vt[v].len, vt[v].base, vt[v].inc, vt[v].scan,
                $sformatf("vec%0d", v));
      end

      // Steady state: write the next line while replaying this one.
      step(1'b0, 4'h0, 1'b0, 1'b1);
      write_line(12, 4'h1, 1'b1, -1, "steady_a");
      step(1'b0, 4'h0, 1'b0, 1'b1);
      for (int t = 0; t < 24; t++) begin
         i = t % 12;
         tick(t % 2 == 0, pix(4'h8, 1'b1, t / 2),
              pix(4'h1, 1'b1, i), i < HSW, "steady", t);
      end
      tick(1'b0, 4'h0, 4'h0, 1'b0, "steady idle", 0);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      replay(12, 4'h8, 1'b1, 1'b0, "steady_b");

      // Early line_reset during COPY1 pixel 5.
      step(1'b0, 4'h0, 1'b0, 1'b1);
      write_line(12, 4'h2, 1'b1, -1, "early_p");
      step(1'b0, 4'h0, 1'b0, 1'b1);
      for (int t = 0; t < 17; t++) begin
         i = (t < 12) ? t : t - 12;
         tick(t % 2 == 0 && t < 12, pix(4'hB, 1'b1, t / 2),
              pix(4'h2, 1'b1, i), i < HSW, "early", t);
      end
      step(1'b0, 4'h0, 1'b0, 1'b1);
      replay(6, 4'hB, 1'b1, 1'b0, "early_q");

      // Zero-length line aborting a copy, then a second empty line.
      step(1'b0, 4'h0, 1'b0, 1'b1);
      write_line(5, 4'h6, 1'b1, -1, "zero_r");
      step(1'b0, 4'h0, 1'b0, 1'b1);
      tick(1'b0, 4'h0, 4'h6, 1'b1, "zero_r", 0);
      tick(1'b0, 4'h0, 4'h7, 1'b1, "zero_r", 1);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      tick(1'b0, 4'h0, 4'h0, 1'b0, "zero", 0);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      tick(1'b0, 4'h0, 4'h0, 1'b0, "zero", 1);

      // Pixel coincident with line_reset lands at index 0.
      step(1'b1, 4'hD, 1'b0, 1'b1);
      write_line(3, 4'hE, 1'b1, -1, "coinc");
      step(1'b0, 4'h0, 1'b0, 1'b1);
      replay(4, 4'hD, 1'b1, 1'b0, "coinc");

      // Asynchronous reset in the middle of COPY0.
      step(1'b0, 4'h0, 1'b0, 1'b1);
      write_line(6, 4'h4, 1'b1, -1, "areset");
      step(1'b0, 4'h0, 1'b0, 1'b1);
      tick(1'b0, 4'h0, 4'h4, 1'b1, "areset", 0);
      tick(1'b0, 4'h0, 4'h5, 1'b1, "areset", 1);
      #2 reset_l = 1'b0;
      #1;
      chk("areset video", 0, dbl_video, 4'h0);
      chk("areset hsync", 0, dbl_hsync, 1'b0);
      chk("areset ovf", 0, overflow, 1'b0);
      @(posedge clk);
      #1 reset_l = 1'b1;
      @(posedge clk);
      #1;
      tick(1'b0, 4'h0, 4'h0, 1'b0, "post_rst", 0);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      write_line(4, 4'h9, 1'b1, -1, "post_rst");
      tick(1'b0, 4'h0, 4'h0, 1'b0, "post_rst", 1);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      replay(4, 4'h9, 1'b1, 1'b0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
